// File: rtl/shift_rotate_seq.sv
// Sequential shift/rotate: applies a one-position op per clock, AMOUNT times; valid pulses for one cycle.
// Latency 1+amount cycles from accept; start is ignored (not queued) while busy.
module shift_rotate_seq #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [2:0]       opcode,
    input  logic [AMT_W-1:0] amount,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_SRA = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SLA = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [2:0]       op_q, op_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] step_x;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic [2:0] op);
        logic [WIDTH-1:0] y;
        case (op)
            OP_SRA:  y = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_SRL:  y = {1'b0, x[WIDTH-1:1]};
            OP_SLA:  y = {x[WIDTH-2:0], 1'b0};
            OP_SLL:  y = {x[WIDTH-2:0], 1'b0};
            OP_ROR:  y = {x[0], x[WIDTH-1:1]};
            OP_ROL:  y = {x[WIDTH-2:0], x[WIDTH-1]};
            default: y = x;
        endcase
        return y;
    endfunction

    assign step_x = step(x_q, op_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d   = a;
                    op_d  = opcode;
                    cnt_d = amount;
                    // Invalid opcodes and zero amounts skip SHIFT entirely
                    if (opcode > OP_ROL) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else if (amount == '0) begin
                        result_d = a;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                x_d   = step_x;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    result_d = step_x;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q != ST_IDLE);
    assign valid  = (state_q == ST_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_shift_rotate_seq.sv
// Bench for shift_rotate_seq: vector table, randomized ops vs arithmetic model, and handshake/reset corners.
module tb_shift_rotate_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [2:0] opcode;
    logic [2:0] amount;
    logic       ready, busy, valid;
    logic [7:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    shift_rotate_seq #(.WIDTH(8), .AMT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .opcode(opcode), .amount(amount),
        .ready(ready), .busy(busy), .valid(valid), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [2:0] op;
        logic [2:0] amt;
        logic [7:0] exp_res;
        int         exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-amount arithmetic, rotates via a doubled operand
    function automatic logic [7:0] model(input logic [7:0] x, input logic [2:0] op, input int amt);
        logic [15:0] dbl;
        logic [15:0] tmp;
        logic [7:0]  r;
        dbl = {x, x};
        r   = 8'hxx;
        case (op)
            3'd0: r = 8'($signed(x) >>> amt);
            3'd1: r = x >> amt;
            3'd2, 3'd3: r = 8'(x << amt);
            3'd4: begin tmp = dbl >> (amt % 8); r = tmp[7:0]; end
            3'd5: begin tmp = dbl << (amt % 8); r = tmp[15:8]; end
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [7:0] ta, input logic [2:0] top, input logic [2:0] tamt,
                          output logic [7:0] res, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_wait", ready, 1);
        start = 1'b1; a = ta; opcode = top; amount = tamt;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); opcode = 3'($urandom); amount = 3'($urandom);
        check("busy_after_accept", {ready, busy}, 2'b01);
        lat = 0;
        while (!valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = result;
        @(negedge clk);
        check("valid_one_cycle", valid, 0);
        check("result_held", result, res);
        check("ready_after_done", ready, 1);
    endtask

    initial begin
        logic [7:0] res;
        int         lat;
        int         pulses;
        int         bad_ready;
        logic [7:0] ra;
        logic [2:0] rop, ramt;

        vecs[0]  = '{8'h96, 3'd0, 3'd3, 8'hF2, 3};
        vecs[1]  = '{8'h81, 3'd4, 3'd1, 8'hC0, 1};
        vecs[2]  = '{8'h81, 3'd5, 3'd7, 8'hC0, 7};
        vecs[3]  = '{8'h80, 3'd1, 3'd7, 8'h01, 7};
        vecs[4]  = '{8'h01, 3'd3, 3'd7, 8'h80, 7};
        vecs[5]  = '{8'h5A, 3'd0, 3'd0, 8'h5A, 0};
        vecs[6]  = '{8'h5A, 3'd4, 3'd0, 8'h5A, 0};
        vecs[7]  = '{8'hFF, 3'd7, 3'd5, 8'h00, 0};
        vecs[8]  = '{8'hFF, 3'd6, 3'd3, 8'h00, 0};
        vecs[9]  = '{8'hA5, 3'd2, 3'd4, 8'h50, 4};
        vecs[10] = '{8'h80, 3'd0, 3'd7, 8'hFF, 7};

        rst = 1'b1; start = 1'b0; a = '0; opcode = '0; amount = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_result", result, 0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].op, vecs[i].amt, res, lat);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        for (int i = 0; i < 40; i++) begin
            ra   = 8'($urandom);
            rop  = 3'($urandom_range(0, 7));
            ramt = 3'($urandom_range(0, 7));
            run_op(ra, rop, ramt, res, lat);
            check($sformatf("rnd%0d_result", i), res, model(ra, rop, int'(ramt)));
            check($sformatf("rnd%0d_latency", i), lat, (rop > 3'd5 || ramt == 3'd0) ? 0 : int'(ramt));
        end

        // start held high through a 7-step rol: only the first request counts
        @(negedge clk);
        start = 1'b1; a = 8'h81; opcode = 3'd5; amount = 3'd7;
        @(negedge clk);
        pulses = 0; bad_ready = 0; lat = -1; res = '0;
        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom); opcode = 3'd1; amount = 3'd2;
            if (valid) begin
                pulses++;
                res   = result;
                lat   = i;
                start = 1'b0;
            end else if (pulses == 0 && ready) begin
                bad_ready++;
            end
            @(negedge clk);
        end
        check("hold_start_pulses", pulses, 1);
        check("hold_start_result", res, 8'hC0);
        check("hold_start_latency", lat, 7);
        check("hold_start_ready_low", bad_ready, 0);

        // reset during the third SHIFT cycle aborts the operation
        start = 1'b1; a = 8'h3C; opcode = 3'd5; amount = 3'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_result", result, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        run_op(8'h3C, 3'd5, 3'd2, res, lat);
        check("post_abort_result", res, 8'hF0);
        check("post_abort_latency", lat, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
